keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry_pkg.sv | 25 ++
 rtl/key_debounce.sv | 48 ++++
 rtl/keypad_entry.sv | 134 +++++++++++++
 tb/tb_keypad_entry.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared constants and types for the keypad time-entry block.
package keypad_entry_pkg;

  localparam int unsigned NUM_KEYS       = 12;
  localparam int unsigned NUM_DIGIT_KEYS = 10;
  localparam int unsigned KEY_START      = 10;
  localparam int unsigned KEY_CANCEL     = 11;
  localparam int unsigned MAX_DIGITS     = 4;
  localparam int unsigned BCD_W          = 16;
  localparam int unsigned CNT_W          = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } entry_state_t;

  typedef logic [3:0] bcd_digit_t;

  // A start is allowed only for a nonzero time whose seconds-tens digit is 0-5.
  function automatic logic time_valid(input logic [BCD_W-1:0] bcd);
    return (bcd != '0) && (bcd[7:4] <= 4'd5);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, level debouncer and registered rising-edge press strobe.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; the last one commits the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad time entry: 12 debounced keys feeding a 4-digit BCD entry FSM.
// Optional beep output is enabled with `define KEYPAD_BEEP_EN.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 20000,
  parameter int unsigned BEEP_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] t,
  output logic [BCD_W-1:0]    time_bcd,
  output logic [CNT_W-1:0]    digit_cnt,
  output logic                start_pulse,
  output logic                cancel_pulse,
  output logic                err_pulse
`ifdef KEYPAD_BEEP_EN
  ,
  output logic                beep
`endif
);

  if (DEB_CYCLES < 1 || BEEP_CYCLES < 1) begin : g_param_check
    $error("keypad_entry: DEB_CYCLES and BEEP_CYCLES must be at least 1");
  end

  logic [NUM_KEYS-1:0] press;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (t[k]),
      .press (press[k])
    );
  end

  entry_state_t     state;
  entry_state_t     state_nxt;
  entry_state_t     eff_state;
  logic             clr_pend;
  logic             clr_nxt;
  logic [BCD_W-1:0] eff_bcd;
  logic [BCD_W-1:0] bcd_nxt;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start_nxt;
  logic             cancel_nxt;
  logic             err_nxt;
  bcd_digit_t       digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      clr_pend     <= 1'b0;
      time_bcd     <= '0;
      digit_cnt    <= '0;
      start_pulse  <= 1'b0;
      cancel_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_pend     <= clr_nxt;
      time_bcd     <= bcd_nxt;
      digit_cnt    <= cnt_nxt;
      start_pulse  <= start_nxt;
      cancel_pulse <= cancel_nxt;
      err_pulse    <= err_nxt;
    end
  end

  // After a start strobe the buffer is treated as empty before any new key is applied.
  always_comb begin
    eff_bcd    = clr_pend ? '0 : time_bcd;
    eff_cnt    = clr_pend ? '0 : digit_cnt;
    eff_state  = clr_pend ? ST_EMPTY : state;
    state_nxt  = eff_state;
    bcd_nxt    = eff_bcd;
    cnt_nxt    = eff_cnt;
    start_nxt  = 1'b0;
    cancel_nxt = 1'b0;
    err_nxt    = 1'b0;
    clr_nxt    = 1'b0;
    digit      = '0;

    for (int i = int'(NUM_DIGIT_KEYS) - 1; i >= 0; i--) begin
      if (press[i]) digit = 4'(i);
    end

    if (press[KEY_CANCEL]) begin
      state_nxt  = ST_EMPTY;
      bcd_nxt    = '0;
      cnt_nxt    = '0;
      cancel_nxt = 1'b1;
    end else if (press[KEY_START]) begin
      if (time_valid(eff_bcd)) begin
        start_nxt = 1'b1;
        clr_nxt   = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (|press[NUM_DIGIT_KEYS-1:0]) begin
      if (eff_state != ST_FULL) begin
        bcd_nxt   = {eff_bcd[BCD_W-5:0], digit};
        cnt_nxt   = eff_cnt + 3'd1;
        state_nxt = (cnt_nxt == CNT_W'(MAX_DIGITS)) ? ST_FULL : ST_ENTRY;
      end
    end
  end

`ifdef KEYPAD_BEEP_EN
  localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] beep_cnt;

  // Any accepted key (re)starts a BEEP_CYCLES-long pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else if (|press) begin
      beep     <= 1'b1;
      beep_cnt <= BEEP_W'(BEEP_CYCLES - 1);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BEEP_W'(1);
    end else begin
      beep <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry with a digit-queue reference model.
module tb_keypad_entry;

  localparam int unsigned DEB  = 4;
  localparam int unsigned BEEP = 16;
  localparam int unsigned LAT  = DEB + 3;

  logic        clk;
  logic        rst_n;
  logic [11:0] t;
  logic [15:0] time_bcd;
  logic [2:0]  digit_cnt;
  logic        start_pulse;
  logic        cancel_pulse;
  logic        err_pulse;
`ifdef KEYPAD_BEEP_EN
  logic        beep;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_digits[$];

  keypad_entry #(
    .DEB_CYCLES (DEB),
    .BEEP_CYCLES(BEEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .t            (t),
    .time_bcd     (time_bcd),
    .digit_cnt    (digit_cnt),
    .start_pulse  (start_pulse),
    .cancel_pulse (cancel_pulse),
    .err_pulse    (err_pulse)
`ifdef KEYPAD_BEEP_EN
    ,
    .beep         (beep)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_bcd();
    logic [15:0] v = '0;
    foreach (m_digits[i]) v = {v[11:0], 4'(m_digits[i])};
    return v;
  endfunction

  // Press a key pattern, check exact latency, strobe cycle, following cycle and silent release.
  task automatic apply_keys(input logic [11:0] keys, input string name);
    logic [15:0] pre_bcd, hold_bcd, post_bcd;
    int          pre_cnt, hold_cnt, post_cnt, idx, bad;
    logic        es, ec, ee;
    pre_bcd = m_bcd();
    pre_cnt = m_digits.size();
    es = 1'b0; ec = 1'b0; ee = 1'b0; idx = 0;
    if (keys[11]) begin
      ec = 1'b1;
      m_digits.delete();
    end else if (keys[10]) begin
      if (pre_bcd != 0 && ((pre_bcd >> 4) & 16'hF) <= 5) es = 1'b1;
      else ee = 1'b1;
    end else if (keys[9:0] != 0) begin
      for (int i = 9; i >= 0; i--) if (keys[i]) idx = i;
      if (m_digits.size() < 4) m_digits.push_back(idx);
    end
    hold_bcd = m_bcd();
    hold_cnt = m_digits.size();
    if (es) m_digits.delete();
    post_bcd = m_bcd();
    post_cnt = m_digits.size();

    @(negedge clk);
    t = keys;
    repeat (LAT - 1) @(posedge clk);
    #1;
    n_checks++;
    if ({start_pulse, cancel_pulse, err_pulse} !== 3'b000 || time_bcd !== pre_bcd) begin
      n_fail++;
      $display("FAIL %s early: strobes=%b bcd=%h, required strobes=000 bcd=%h",
               name, {start_pulse, cancel_pulse, err_pulse}, time_bcd, pre_bcd);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({start_pulse, cancel_pulse, err_pulse} !== {es, ec, ee} || time_bcd !== hold_bcd ||
        digit_cnt !== 3'(hold_cnt)) begin
      n_fail++;
      $display("FAIL %s accept: strobes=%b bcd=%h cnt=%0d, required strobes=%b bcd=%h cnt=%0d",
               name, {start_pulse, cancel_pulse, err_pulse}, time_bcd, digit_cnt,
               {es, ec, ee}, hold_bcd, hold_cnt);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({start_pulse, cancel_pulse, err_pulse} !== 3'b000 || time_bcd !== post_bcd ||
        digit_cnt !== 3'(post_cnt)) begin
      n_fail++;
      $display("FAIL %s after: strobes=%b bcd=%h cnt=%0d, required strobes=000 bcd=%h cnt=%0d",
               name, {start_pulse, cancel_pulse, err_pulse}, time_bcd, digit_cnt,
               post_bcd, post_cnt);
    end
    @(negedge clk);
    t = '0;
    bad = 0;
    repeat (DEB + 4) begin
      @(posedge clk);
      #1;
      if (start_pulse || cancel_pulse || err_pulse || time_bcd !== post_bcd) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s release: %0d disturbed cycles, required 0", name, bad);
    end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (time_bcd !== m_bcd() || digit_cnt !== 3'(m_digits.size()) ||
        {start_pulse, cancel_pulse, err_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s: bcd=%h cnt=%0d strobes=%b, required bcd=%h cnt=%0d strobes=000",
               name, time_bcd, digit_cnt, {start_pulse, cancel_pulse, err_pulse},
               m_bcd(), m_digits.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t = '0;
    repeat (3) @(posedge clk);
    #1;
    m_digits.delete();
    check_idle("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    apply_keys(12'h002, "fill_1");
    apply_keys(12'h004, "fill_2");
    apply_keys(12'h008, "fill_3");
    apply_keys(12'h001, "fill_0");
    n_checks++;
    if (time_bcd !== 16'h1230 || digit_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full: bcd=%h cnt=%0d, required 1230 cnt=4", time_bcd, digit_cnt);
    end
    apply_keys(12'h200, "full_ignore_9");
  endtask

  task automatic test_start();
    apply_keys(12'h800, "cancel_full");
    apply_keys(12'h020, "start_digit_5");
    apply_keys(12'h400, "start_valid");
  endtask

  task automatic test_error();
    apply_keys(12'h400, "start_empty");
    apply_keys(12'h001, "err_0");
    apply_keys(12'h080, "err_7");
    apply_keys(12'h001, "err_0b");
    apply_keys(12'h400, "start_h2_7");
    apply_keys(12'h800, "err_cancel");
  endtask

  task automatic test_glitch();
    int bad;
    @(negedge clk);
    t = 12'h008;
    repeat (2) @(posedge clk);
    @(negedge clk);
    t = '0;
    bad = 0;
    repeat (2 * DEB + 6) begin
      @(posedge clk);
      #1;
      if (start_pulse || cancel_pulse || err_pulse || digit_cnt !== 3'(m_digits.size())) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL glitch: %0d disturbed cycles, required 0", bad);
    end
    @(negedge clk);
    t = 12'h008;
    repeat (20) @(posedge clk);
    @(negedge clk);
    t = '0;
    repeat (DEB + 6) @(posedge clk);
    #1;
    m_digits.push_back(3);
    check_idle("hold_20_single");
  endtask

  task automatic test_simultaneous();
    apply_keys(12'h002, "simul_pre_1");
    apply_keys(12'h810, "cancel_and_4");
    apply_keys(12'h440, "start_and_6_empty");
    apply_keys(12'h0A0, "digits_5_and_7");
    apply_keys(12'h800, "simul_clear");
  endtask

  task automatic test_reset_mid_entry();
    apply_keys(12'h001, "rst_0");
    apply_keys(12'h002, "rst_1");
    apply_keys(12'h004, "rst_2");
    n_checks++;
    if (time_bcd !== 16'h0012 || digit_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_reset: bcd=%h cnt=%0d, required 0012 cnt=3", time_bcd, digit_cnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_digits.delete();
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_held();
    @(negedge clk);
    t = 12'h040;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check_idle("held_early");
    @(posedge clk);
    #1;
    m_digits.push_back(6);
    check_idle("held_accept");
    @(negedge clk);
    t = '0;
    repeat (DEB + 4) @(posedge clk);
    #1;
    check_idle("held_once");
  endtask

  task automatic test_reset_mid_debounce();
    @(negedge clk);
    t = 12'h020;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    t = '0;
    m_digits.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DEB + 6) @(posedge clk);
    #1;
    check_idle("pending_discard");
  endtask

  task automatic test_random();
    int          r;
    logic [11:0] keys;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 19);
      if (r < 12) keys = 12'(1 << (r % 10));
      else if (r < 15) keys = 12'h400;
      else if (r < 16) keys = 12'h800;
      else keys = 12'(1 << $urandom_range(0, 11)) | 12'(1 << $urandom_range(0, 11));
      apply_keys(keys, $sformatf("rand_%0d_%h", n, keys));
    end
  endtask

`ifdef KEYPAD_BEEP_EN
  task automatic test_beep();
    int lat, cnt;
    @(negedge clk);
    t = 12'h100;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!beep && lat < 50);
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL beep_latency: %0d cycles, required %0d", lat, LAT);
    end
    cnt = 1;
    while (cnt < 200) begin
      @(posedge clk);
      #1;
      if (!beep) break;
      cnt++;
    end
    n_checks++;
    if (cnt != BEEP) begin
      n_fail++;
      $display("FAIL beep_length: %0d cycles, required %0d", cnt, BEEP);
    end
    @(negedge clk);
    t = '0;
    repeat (DEB + 4) @(posedge clk);
    @(negedge clk);
    t = 12'h004;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!beep && lat < 50);
    cnt = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (beep) cnt++;
    end
    @(negedge clk);
    t = 12'h084;
    while (cnt < 200) begin
      @(posedge clk);
      #1;
      if (!beep) break;
      cnt++;
    end
    n_checks++;
    if (cnt != DEB + 8 + BEEP) begin
      n_fail++;
      $display("FAIL beep_retrigger: %0d cycles, required %0d", cnt, DEB + 8 + BEEP);
    end
    @(negedge clk);
    t = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_start();
    test_error();
    test_glitch();
    test_simultaneous();
    test_reset_mid_entry();
    test_reset_held();
    test_reset_mid_debounce();
    test_random();
`ifdef KEYPAD_BEEP_EN
    test_beep();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
